// File: rtl/draw_pkg.sv
// draw_pkg: shared geometry, sprite indices and blit state for the draw-screen controller.
// Ports: none.
package draw_pkg;
    localparam int SCREEN_WIDTH  = 320;
    localparam int SCREEN_HEIGHT = 180;
    localparam int SPRITE_SIZE   = 32;
    localparam int SPRITE_LOG2   = $clog2(SPRITE_SIZE);
    localparam int COORD_W       = 11;
    localparam logic [3:0] BG    = 4'd0;
    localparam logic [3:0] BL    = 4'd1;
    localparam logic [3:0] FH    = 4'd2;
    localparam logic [3:0] WH    = 4'd3;
    localparam logic [3:0] HD    = 4'd4;
    localparam logic [3:0] SEL   = 4'd6;
    localparam logic [3:0] MODE  = 4'd7;
    localparam logic [3:0] PAUSE = 4'd8;
    localparam logic [3:0] FAIL  = 4'd9;
    localparam logic [3:0] WIN   = 4'd10;
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} blit_state_e;
endpackage

// File: rtl/blit_clip_addr.sv
// blit_clip_addr: registered clip test and VRAM address for one pixel, 1-cycle latency.
// Ports: CLK, rst; valid_i/px_i/py_i pixel in (11-bit two's complement); addr_o/valid_o pixel out.
module blit_clip_addr import draw_pkg::*; #(
    parameter int VRAM_A_WIDTH = 16
) (
    input  logic                    CLK,
    input  logic                    rst,
    input  logic                    valid_i,
    input  logic [COORD_W-1:0]      px_i,
    input  logic [COORD_W-1:0]      py_i,
    output logic [VRAM_A_WIDTH-1:0] addr_o,
    output logic                    valid_o
);
    logic                    in_bounds_d;
    logic [VRAM_A_WIDTH-1:0] addr_d;
    logic [VRAM_A_WIDTH-1:0] addr_q;
    logic                    valid_q;
    // Sign bit clear means non-negative, so the upper bound is a plain unsigned compare.
    assign in_bounds_d = !px_i[COORD_W-1] && !py_i[COORD_W-1] &&
                         px_i < COORD_W'(SCREEN_WIDTH) && py_i < COORD_W'(SCREEN_HEIGHT);
    assign addr_d = VRAM_A_WIDTH'(py_i) * VRAM_A_WIDTH'(SCREEN_WIDTH) + VRAM_A_WIDTH'(px_i);
    always_ff @(posedge CLK) begin
        if (rst) begin
            addr_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            valid_q <= valid_i && in_bounds_d;
        end
    end
    assign addr_o  = addr_q;
    assign valid_o = valid_q;
endmodule

// File: rtl/sprite_blit_engine.sv
// sprite_blit_engine: walks one sprite and emits ROM read and clipped VRAM write addresses.
// Ports: CLK, rst; i_start/i_abort control; i_x/i_y top-left (signed); i_sprite_idx sprite number;
//        o_address_s ROM address; o_address_screen/o_valid VRAM write one cycle later; o_busy, o_done.
module sprite_blit_engine import draw_pkg::*; #(
    parameter int VRAM_A_WIDTH      = 16,
    parameter int SPRITEBUF_A_WIDTH = 15,
    parameter int SPRITE_IDX_WIDTH  = 4
) (
    input  logic                         CLK,
    input  logic                         rst,
    input  logic                         i_start,
    input  logic                         i_abort,
    input  logic [9:0]                   i_x,
    input  logic [9:0]                   i_y,
    input  logic [SPRITE_IDX_WIDTH-1:0]  i_sprite_idx,
    output logic [SPRITEBUF_A_WIDTH-1:0] o_address_s,
    output logic [VRAM_A_WIDTH-1:0]      o_address_screen,
    output logic                         o_valid,
    output logic                         o_busy,
    output logic                         o_done
);
    blit_state_e                 state_q;
    logic [SPRITE_LOG2-1:0]      sx_q, sy_q;
    logic [9:0]                  x_q, y_q;
    logic [SPRITE_IDX_WIDTH-1:0] idx_q;
    logic                        done_q;
    logic                        last_px;
    logic [COORD_W-1:0]          px, py;
    assign last_px = &{sy_q, sx_q};
    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q <= IDLE;
            sx_q    <= '0;
            sy_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= state_q == FLUSH && !i_abort;
            // Abort dominates everything, including a start arriving in IDLE.
            if (i_abort) begin
                state_q <= IDLE;
                sx_q    <= '0;
                sy_q    <= '0;
            end else begin
                case (state_q)
                    IDLE: if (i_start) begin
                        state_q <= RUN;
                        x_q     <= i_x;
                        y_q     <= i_y;
                        idx_q   <= i_sprite_idx;
                        sx_q    <= '0;
                        sy_q    <= '0;
                    end
                    RUN: begin
                        {sy_q, sx_q} <= {sy_q, sx_q} + (2*SPRITE_LOG2)'(1);
                        if (last_px) state_q <= FLUSH;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
    // Sprite size is a power of two, so idx*S^2 + sy*S + sx is a plain concatenation.
    assign o_address_s = SPRITEBUF_A_WIDTH'({idx_q, sy_q, sx_q});
    assign px = {x_q[9], x_q} + COORD_W'(sx_q);
    assign py = {y_q[9], y_q} + COORD_W'(sy_q);
    blit_clip_addr #(.VRAM_A_WIDTH(VRAM_A_WIDTH)) u_clip (
        .CLK     (CLK),
        .rst     (rst),
        .valid_i (state_q == RUN && !i_abort),
        .px_i    (px),
        .py_i    (py),
        .addr_o  (o_address_screen),
        .valid_o (o_valid)
    );
    assign o_busy = state_q != IDLE;
    assign o_done = done_q;
endmodule

// File: tb/tb_sprite_blit_engine.sv
// tb_sprite_blit_engine: directed self-checking bench for sprite_blit_engine.
module tb_sprite_blit_engine;
    logic        CLK = 1'b0;
    logic        rst, i_start, i_abort;
    logic [9:0]  i_x, i_y;
    logic [3:0]  i_sprite_idx;
    logic [14:0] o_address_s;
    logic [15:0] o_address_screen;
    logic        o_valid, o_busy, o_done;
    int          n_checks = 0;
    int          n_err = 0;
    int          busy, nvalid, ndone_mid, first_vcyc;
    logic [31:0] first_s, first_scr, last_s, last_scr;
    logic        done_end;

    sprite_blit_engine dut (
        .CLK              (CLK),
        .rst              (rst),
        .i_start          (i_start),
        .i_abort          (i_abort),
        .i_x              (i_x),
        .i_y              (i_y),
        .i_sprite_idx     (i_sprite_idx),
        .o_address_s      (o_address_s),
        .o_address_screen (o_address_screen),
        .o_valid          (o_valid),
        .o_busy           (o_busy),
        .o_done           (o_done)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic outputs_zero(input string tag);
        chk({tag, " addr_s"}, 32'(o_address_s), 0);
        chk({tag, " addr_scr"}, 32'(o_address_screen), 0);
        chk({tag, " valid"}, 32'(o_valid), 0);
        chk({tag, " busy"}, 32'(o_busy), 0);
        chk({tag, " done"}, 32'(o_done), 0);
    endtask

    // Runs one full blit, pairing each valid pulse with the ROM address of the previous cycle.
    task automatic run_blit(input logic [9:0] x, input logic [9:0] y, input logic [3:0] idx);
        logic [31:0] prev_s;
        i_x = x;
        i_y = y;
        i_sprite_idx = idx;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        busy = 0;
        nvalid = 0;
        ndone_mid = 0;
        first_vcyc = 0;
        first_s = '1;
        first_scr = '1;
        last_s = '1;
        last_scr = '1;
        prev_s = '1;
        while (o_busy && busy < 2000) begin
            busy++;
            if (o_done) ndone_mid++;
            if (o_valid) begin
                if (nvalid == 0) begin
                    first_vcyc = busy;
                    first_s = prev_s;
                    first_scr = 32'(o_address_screen);
                end
                nvalid++;
                last_s = prev_s;
                last_scr = 32'(o_address_screen);
            end
            prev_s = 32'(o_address_s);
            step();
        end
        done_end = o_done;
    endtask

    initial begin
        rst = 1'b1;
        i_start = 1'b0;
        i_abort = 1'b0;
        i_x = '0;
        i_y = '0;
        i_sprite_idx = '0;
        step();
        step();
        outputs_zero("reset");
        rst = 1'b0;
        step();
        chk("idle busy", 32'(o_busy), 0);

        run_blit(10'd0, 10'd0, 4'd1);
        chk("t1 busy cycles", 32'(busy), 1025);
        chk("t1 valid count", 32'(nvalid), 1024);
        chk("t1 early done", 32'(ndone_mid), 0);
        chk("t1 done", 32'(done_end), 1);
        chk("t1 first addr_s", first_s, 1024);
        chk("t1 first scr", first_scr, 0);
        chk("t1 first valid cycle", 32'(first_vcyc), 2);
        chk("t1 last addr_s", last_s, 2047);
        chk("t1 last scr", last_scr, 9951);
        step();
        chk("t1 done one cycle", 32'(o_done), 0);

        run_blit(10'd300, 10'd170, 4'd0);
        chk("t2 busy cycles", 32'(busy), 1025);
        chk("t2 valid count", 32'(nvalid), 200);
        chk("t2 first scr", first_scr, 170 * 320 + 300);
        chk("t2 last scr", last_scr, 57599);
        chk("t2 done", 32'(done_end), 1);

        run_blit(10'h3F6, 10'h3FB, 4'd2);
        chk("t3 valid count", 32'(nvalid), 594);
        chk("t3 first addr_s", first_s, 2048 + 170);
        chk("t3 first scr", first_scr, 0);
        chk("t3 first valid cycle", 32'(first_vcyc), 172);
        chk("t3 last scr", last_scr, 26 * 320 + 21);
        chk("t3 busy cycles", 32'(busy), 1025);

        run_blit(10'd400, 10'd0, 4'd5);
        chk("t4 valid count", 32'(nvalid), 0);
        chk("t4 busy cycles", 32'(busy), 1025);
        chk("t4 done", 32'(done_end), 1);

        i_x = 10'd0;
        i_y = 10'd0;
        i_sprite_idx = 4'd1;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        repeat (99) step();
        chk("t5 addr_s at 100", 32'(o_address_s), 1024 + 99);
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        chk("t5 abort busy", 32'(o_busy), 0);
        chk("t5 abort valid", 32'(o_valid), 0);
        chk("t5 abort done", 32'(o_done), 0);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        chk("t5 restart busy", 32'(o_busy), 1);
        chk("t5 restart addr_s", 32'(o_address_s), 1024);
        step();
        chk("t5 restart addr_s 2", 32'(o_address_s), 1025);
        chk("t5 restart valid", 32'(o_valid), 1);
        chk("t5 restart scr", 32'(o_address_screen), 0);
        i_abort = 1'b1;
        step();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        i_abort = 1'b0;
        chk("t5 abort beats start", 32'(o_busy), 0);
        step();
        chk("t5 no done after abort", 32'(o_done), 0);

        i_sprite_idx = 4'd3;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        repeat (49) step();
        i_sprite_idx = 4'd7;
        i_x = 10'd100;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        chk("t6 busy", 32'(o_busy), 1);
        chk("t6 addr_s at 51", 32'(o_address_s), 3072 + 50);
        step();
        chk("t6 addr_s at 52", 32'(o_address_s), 3072 + 51);
        chk("t6 scr unchanged", 32'(o_address_screen), 320 + 18);
        chk("t6 valid", 32'(o_valid), 1);
        repeat (448) step();
        chk("t6 addr_s at 500", 32'(o_address_s), 3072 + 499);
        rst = 1'b1;
        step();
        outputs_zero("t6 rst");
        rst = 1'b0;
        step();
        chk("t6 idle after rst", 32'(o_busy), 0);
        chk("t6 no done after rst", 32'(o_done), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
